alu_issue_ctrl: RTL and testbench

//  Issue/sequencing controller in front of the 64-bit Alu (combinational ops + pipelined multiplier).

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_resp_fifo.sv | 63 ++++++
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and response record for the Alu issue path.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h07;
  localparam logic [5:0] OP_AND = 6'h08;
  localparam logic [5:0] OP_OR  = 6'h09;
  localparam logic [5:0] OP_XOR = 6'h0A;
  localparam logic [5:0] OP_SHL = 6'h0B;
  localparam logic [5:0] OP_SHR = 6'h0C;
  localparam logic [5:0] OP_SRA = 6'h0D;
  localparam logic [5:0] OP_EQ  = 6'h0E;
  localparam logic [5:0] OP_NE  = 6'h0F;
  localparam logic [5:0] OP_LT  = 6'h10;
  localparam logic [5:0] OP_LTU = 6'h11;
  localparam logic [5:0] OP_GE  = 6'h12;
  localparam logic [5:0] OP_GEU = 6'h13;
  localparam logic [5:0] OP_MUL = 6'h14;

  localparam int RESP_TAG_W = 5;

  typedef struct packed {
    logic [63:0]           data;
    logic [RESP_TAG_W-1:0] tag;
    logic                  illegal;
  } resp_t;

  function automatic logic is_mult(input logic [5:0] op);
    return op == OP_MUL;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_ADD) || ((op >= OP_SUB) && (op <= OP_MUL));
  endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// In-order response buffer; push and pop may coincide at any occupancy, pop when empty is ignored.
module alu_resp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  resp_t                      push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output resp_t                      head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  resp_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller in front of the 64-bit Alu: registers accepted ops, tracks the
// pipelined multiplier and returns results in accept order through a credit-protected FIFO.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_LAT    = 3,
  parameter int RESP_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [5:0]       io_req_op,
  input  logic [63:0]      io_req_a,
  input  logic [63:0]      io_req_b,
  input  logic [TAG_W-1:0] io_req_tag,
  output logic [5:0]       io_alu_op,
  output logic [63:0]      io_alu_a,
  output logic [63:0]      io_alu_b,
  input  logic [63:0]      io_alu_out,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [63:0]      io_resp_data,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic             io_resp_illegal
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high; the
  // offering side holds its payload stable until then, and ready never depends on valid.

  localparam int PIPE_N = MUL_LAT - 1;
  localparam int MC_W   = $clog2(MUL_LAT + 1);
  localparam int FC_W   = $clog2(RESP_DEPTH + 1);
  localparam int OUT_W  = $clog2(RESP_DEPTH + MUL_LAT + 2);

  logic             issue_v_q;
  logic [5:0]       issue_op_q;
  logic [63:0]      issue_a_q, issue_b_q;
  logic [TAG_W-1:0] issue_tag_q;

  logic [PIPE_N-1:0] mpipe_v_q;
  logic [TAG_W-1:0]  mpipe_tag_q [PIPE_N];
  logic [MC_W-1:0]   mult_cnt_q, mult_cnt_d;

  logic             fire, mult_busy, credit_ok;
  logic             mult_enter, mult_exit, nonmult_done, push;
  logic             head_valid;
  logic [FC_W-1:0]  fifo_count;
  logic [OUT_W-1:0] outstanding;
  resp_t            push_data, head;

  assign mult_busy   = (mult_cnt_q != '0) | (issue_v_q & is_mult(issue_op_q));
  assign outstanding = OUT_W'(issue_v_q) + OUT_W'(mult_cnt_q) + OUT_W'(fifo_count);
  assign credit_ok   = outstanding < OUT_W'(RESP_DEPTH);
  // A non-mult would overtake an in-flight product, so it waits; mults stream back to back.
  assign io_req_ready = credit_ok & (is_mult(io_req_op) | ~mult_busy);
  assign fire         = io_req_valid & io_req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_v_q   <= 1'b0;
      issue_op_q  <= OP_ADD;
      issue_a_q   <= '0;
      issue_b_q   <= '0;
      issue_tag_q <= '0;
    end else if (fire) begin
      issue_v_q   <= 1'b1;
      issue_op_q  <= io_req_op;
      issue_a_q   <= io_req_a;
      issue_b_q   <= io_req_b;
      issue_tag_q <= io_req_tag;
    end else begin
      issue_v_q  <= 1'b0;
      issue_op_q <= OP_ADD;
    end
  end

  assign io_alu_op = issue_op_q;
  assign io_alu_a  = issue_a_q;
  assign io_alu_b  = issue_b_q;

  assign mult_enter   = issue_v_q & is_mult(issue_op_q);
  assign mult_exit    = mpipe_v_q[PIPE_N-1];
  assign nonmult_done = issue_v_q & ~is_mult(issue_op_q);

  // Shadow of the multiplier: tags ride alongside until the product shows up on io_alu_out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mpipe_v_q <= '0;
      for (int i = 0; i < PIPE_N; i++) mpipe_tag_q[i] <= '0;
    end else begin
      mpipe_v_q[0]   <= mult_enter;
      mpipe_tag_q[0] <= issue_tag_q;
      for (int i = 1; i < PIPE_N; i++) begin
        mpipe_v_q[i]   <= mpipe_v_q[i-1];
        mpipe_tag_q[i] <= mpipe_tag_q[i-1];
      end
    end
  end

  always_comb begin
    mult_cnt_d = mult_cnt_q;
    if (mult_enter && !mult_exit) mult_cnt_d = mult_cnt_q + 1'b1;
    else if (!mult_enter && mult_exit) mult_cnt_d = mult_cnt_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mult_cnt_q <= '0;
    else       mult_cnt_q <= mult_cnt_d;
  end

  // The ordering rule guarantees at most one of the two completion sources per cycle.
  always_comb begin
    push_data         = '0;
    push              = nonmult_done | mult_exit;
    push_data.illegal = nonmult_done & ~is_legal(issue_op_q);
    push_data.data    = push_data.illegal ? 64'd0 : io_alu_out;
    push_data.tag     = mult_exit ? RESP_TAG_W'(mpipe_tag_q[PIPE_N-1])
                                  : RESP_TAG_W'(issue_tag_q);
  end

  alu_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (io_resp_ready),
    .valid_o     (head_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign io_resp_valid   = head_valid;
  assign io_resp_data    = head.data;
  assign io_resp_tag     = TAG_W'(head.tag);
  assign io_resp_illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural Alu stand-in and an in-order scoreboard.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int MUL_LAT    = 3;
  localparam int RESP_DEPTH = 4;
  localparam int TAG_W      = 5;
  localparam int RW         = 64 + TAG_W + 1;

  logic             clock, reset;
  logic             io_req_valid, io_req_ready;
  logic [5:0]       io_req_op;
  logic [63:0]      io_req_a, io_req_b;
  logic [TAG_W-1:0] io_req_tag;
  logic [5:0]       io_alu_op;
  logic [63:0]      io_alu_a, io_alu_b, io_alu_out;
  logic             io_resp_valid, io_resp_ready;
  logic [63:0]      io_resp_data;
  logic [TAG_W-1:0] io_resp_tag;
  logic             io_resp_illegal;

  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(
    .MUL_LAT(MUL_LAT), .RESP_DEPTH(RESP_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_op(io_req_op),
    .io_req_a(io_req_a), .io_req_b(io_req_b), .io_req_tag(io_req_tag),
    .io_alu_op(io_alu_op), .io_alu_a(io_alu_a), .io_alu_b(io_alu_b), .io_alu_out(io_alu_out),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready), .io_resp_data(io_resp_data),
    .io_resp_tag(io_resp_tag), .io_resp_illegal(io_resp_illegal)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Alu stand-in ----------------
  function automatic logic [63:0] alu_comb(input logic [5:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[5:0];
      OP_SHR:  return a >> b[5:0];
      OP_SRA:  return 64'($signed(a) >>> b[5:0]);
      OP_EQ:   return {63'd0, a == b};
      OP_NE:   return {63'd0, a != b};
      OP_LT:   return {63'd0, $signed(a) < $signed(b)};
      OP_LTU:  return {63'd0, a < b};
      OP_GE:   return {63'd0, $signed(a) >= $signed(b)};
      OP_GEU:  return {63'd0, a >= b};
      default: return 64'd0;
    endcase
  endfunction

  logic        mv1_q, mv2_q;
  logic [63:0] mp1_q, mp2_q;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mv1_q <= 1'b0; mv2_q <= 1'b0; mp1_q <= '0; mp2_q <= '0;
    end else begin
      mv1_q <= (io_alu_op == OP_MUL);
      mp1_q <= io_alu_a * io_alu_b;
      mv2_q <= mv1_q;
      mp2_q <= mp1_q;
    end
  end

  always_comb io_alu_out = mv2_q ? mp2_q : alu_comb(io_alu_op, io_alu_a, io_alu_b);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_req(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [TAG_W-1:0] tag);
    io_req_valid = 1'b1;
    io_req_op    = op;
    io_req_a     = a;
    io_req_b     = b;
    io_req_tag   = tag;
  endtask

  // Offers one op at a negedge, expects immediate acceptance, returns at the next negedge.
  task automatic send(input string name, input logic [5:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [TAG_W-1:0] tag);
    drive_req(op, a, b, tag);
    #1;
    check({name, "_rdy"}, io_req_ready, 1);
    @(negedge clock);
    io_req_valid = 1'b0;
  endtask

  task automatic single_op(input string name, input logic [5:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [TAG_W-1:0] tag,
                           input logic [63:0] exp_data, input logic exp_ill, input int lat);
    io_resp_ready = 1'b1;
    send(name, op, a, b, tag);
    for (int k = 1; k < lat; k++) begin
      check({name, "_early"}, io_resp_valid, 0);
      @(negedge clock);
    end
    check({name, "_vld"}, io_resp_valid, 1);
    check({name, "_data"}, io_resp_data, exp_data);
    check({name, "_tag"}, io_resp_tag, tag);
    check({name, "_ill"}, io_resp_illegal, exp_ill);
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] mul_exp [3];
    logic [RW-1:0] got, expv;
    int sent;

    reset = 1'b1;
    io_req_valid = 1'b0; io_req_op = '0; io_req_a = '0; io_req_b = '0; io_req_tag = '0;
    io_resp_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_resp_vld", io_resp_valid, 0);
    check("rst_resp_data", io_resp_data, 0);
    check("rst_resp_tag", io_resp_tag, 0);
    check("rst_resp_ill", io_resp_illegal, 0);
    check("rst_alu_op", io_alu_op, 0);
    check("rst_alu_a", io_alu_a, 0);
    reset = 1'b0;
    @(negedge clock);

    // ADD: drives the Alu the next cycle, result two cycles after accept
    drive_req(OP_ADD, 64'd5, 64'd7, 5'd3);
    #1 check("add_rdy", io_req_ready, 1);
    @(negedge clock);
    io_req_valid = 1'b0;
    check("add_alu_op", io_alu_op, OP_ADD);
    check("add_alu_a", io_alu_a, 64'd5);
    check("add_alu_b", io_alu_b, 64'd7);
    check("add_early", io_resp_valid, 0);
    @(negedge clock);
    check("add_vld", io_resp_valid, 1);
    check("add_data", io_resp_data, 64'd12);
    check("add_tag", io_resp_tag, 5'd3);
    check("add_ill", io_resp_illegal, 0);
    @(negedge clock);
    check("add_pop", io_resp_valid, 0);

    // single MUL: result MUL_LAT+1 cycles after accept
    single_op("mul", OP_MUL, 64'd6, 64'd7, 5'd4, 64'd42, 1'b0, MUL_LAT + 1);

    // three MULs back to back
    mul_exp[0] = 64'd6; mul_exp[1] = 64'd20; mul_exp[2] = 64'd110;
    send("mul3_0", OP_MUL, 64'd2, 64'd3, 5'd10);
    send("mul3_1", OP_MUL, 64'd4, 64'd5, 5'd11);
    send("mul3_2", OP_MUL, 64'd10, 64'd11, 5'd12);
    check("mul3_early", io_resp_valid, 0);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check("mul3_vld", io_resp_valid, 1);
      check("mul3_data", io_resp_data, mul_exp[i]);
      check("mul3_tag", io_resp_tag, 10 + i);
      @(negedge clock);
    end
    check("mul3_done", io_resp_valid, 0);

    // MUL then SUB: SUB waits for the product to drain
    send("ord_mul", OP_MUL, 64'd6, 64'd7, 5'd1);
    drive_req(OP_SUB, 64'd9, 64'd4, 5'd2);
    for (int k = 0; k < MUL_LAT; k++) begin
      #1 check("ord_sub_held", io_req_ready, 0);
      @(negedge clock);
    end
    #1 check("ord_sub_rdy", io_req_ready, 1);
    check("ord_first_vld", io_resp_valid, 1);
    check("ord_first_data", io_resp_data, 64'd42);
    check("ord_first_tag", io_resp_tag, 5'd1);
    @(negedge clock);
    io_req_valid = 1'b0;
    check("ord_gap", io_resp_valid, 0);
    @(negedge clock);
    check("ord_second_vld", io_resp_valid, 1);
    check("ord_second_data", io_resp_data, 64'd5);
    check("ord_second_tag", io_resp_tag, 5'd2);
    @(negedge clock);

    // credit limit: consumer stalled, six ADDs offered
    io_resp_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      drive_req(OP_ADD, 64'(sent), 64'd100, 5'(sent));
      #1;
      if (io_req_ready) begin
        exp_q.push_back({64'(sent) + 64'd100, 5'(sent), 1'b0});
        sent++;
      end
      @(negedge clock);
    end
    check("cred_accepted", sent, 4);
    #1 check("cred_rdy_low", io_req_ready, 0);
    check("cred_head_vld", io_resp_valid, 1);
    check("cred_head_data", io_resp_data, 64'd100);
    check("cred_head_tag", io_resp_tag, 5'd0);
    @(negedge clock);
    io_resp_ready = 1'b1;
    for (int c = 0; c < 40 && (sent < 6 || exp_q.size() > 0); c++) begin
      if (io_resp_valid) begin
        got = {io_resp_data, io_resp_tag, io_resp_illegal};
        if (exp_q.size() == 0) begin
          check("sb_extra", 1, 0);
        end else begin
          expv = exp_q.pop_front();
          check("sb_order", got, expv);
        end
      end
      if (sent < 6) drive_req(OP_ADD, 64'(sent), 64'd100, 5'(sent));
      else io_req_valid = 1'b0;
      #1;
      if (io_req_valid && io_req_ready) begin
        exp_q.push_back({64'(sent) + 64'd100, 5'(sent), 1'b0});
        sent++;
      end
      @(negedge clock);
    end
    io_req_valid = 1'b0;
    check("sb_sent", sent, 6);
    check("sb_empty", exp_q.size(), 0);
    check("sb_idle", io_resp_valid, 0);

    // illegal opcode and GEU boundary
    single_op("ill", 6'h3F, 64'd1, 64'd2, 5'd7, 64'd0, 1'b1, 2);
    single_op("geu", OP_GEU, 64'd3, 64'd3, 5'd8, 64'd1, 1'b0, 2);

    // reset with two FIFO entries and two mults in flight
    io_resp_ready = 1'b0;
    send("rsm_add0", OP_ADD, 64'd1, 64'd1, 5'd1);
    send("rsm_add1", OP_ADD, 64'd2, 64'd2, 5'd2);
    send("rsm_mul0", OP_MUL, 64'd3, 64'd3, 5'd3);
    send("rsm_mul1", OP_MUL, 64'd4, 64'd4, 5'd4);
    check("rsm_pre_vld", io_resp_valid, 1);
    check("rsm_pre_data", io_resp_data, 64'd2);
    reset = 1'b1;
    #1;
    check("rsm_vld", io_resp_valid, 0);
    check("rsm_data", io_resp_data, 0);
    check("rsm_tag", io_resp_tag, 0);
    check("rsm_alu_op", io_alu_op, 0);
    @(negedge clock);
    reset = 1'b0;
    io_resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("rsm_stale", io_resp_valid, 0);
      @(negedge clock);
    end
    single_op("rsm_after", OP_ADD, 64'd20, 64'd22, 5'd9, 64'd42, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
